// File: rtl/bpred_update_gen.sv
// Execute-side branch-predictor update generator.
// Each resolved branch is checked against the prediction carried down from fetch.
// A mispredict produces a registered fetch redirect. Every resolved branch also queues
// a BTB/bimodal training packet in a small in-order FIFO. That FIFO drains into the
// predictor only on cycles where the predictor is not stalled.
// Optional build macro: BPU_UPD_STATS_EN adds stat_sel/stat_data and four saturating
// event counters (pushes, drops, misses resolved, redirects).

`timescale 1ns/1ps

module bpred_update_gen #(
  parameter int QDEPTH = 4,
  parameter int QAW    = 2
) (
`ifdef BPU_UPD_STATS_EN
  input  logic [1:0]  stat_sel,
  output logic [31:0] stat_data,
`endif
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc4,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_dir,
  input  logic [31:0] ex_pred_target,
  input  logic [11:0] ex_bimodal,
  input  logic [8:0]  ex_carry,
  input  logic        soin_bpredictor_stall,
  output logic        execute_bpredictor_update,
  output logic [31:0] execute_bpredictor_PC4,
  output logic [31:0] execute_bpredictor_target,
  output logic        execute_bpredictor_dir,
  output logic        execute_bpredictor_miss,
  output logic [11:0] execute_bpredictor_bimodal,
  output logic [29:0] up_btb_data,
  output logic [8:0]  up_carry_data,
  output logic [3:0]  byte_en,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  localparam logic [QAW:0]   DEPTH_C = QDEPTH[QAW:0];
  localparam logic [QAW-1:0] PTR_ONE = {{(QAW-1){1'b0}}, 1'b1};
  localparam logic [QAW:0]   CNT_ONE = {{QAW{1'b0}}, 1'b1};

  // FIFO storage, one array per packet field
  logic [31:0] pc4_q   [QDEPTH];
  logic [31:0] tgt_q   [QDEPTH];
  logic        dir_q   [QDEPTH];
  logic        miss_q  [QDEPTH];
  logic [11:0] bim_q   [QDEPTH];
  logic [8:0]  carry_q [QDEPTH];
  logic [3:0]  be_q    [QDEPTH];

  logic [QAW-1:0] wr_ptr_q, wr_ptr_d;
  logic [QAW-1:0] rd_ptr_q, rd_ptr_d;
  logic [QAW:0]   count_q,  count_d;

  logic        redir_valid_q, redir_valid_d;
  logic [31:0] redir_pc_q,    redir_pc_d;

  logic [31:0] correct_pc;
  logic        res_miss;
  logic        btb_wr;
  logic [3:0]  res_be;
  logic        not_empty;
  logic        pop;
  logic        push;
  logic        drop;

  // Resolve the branch currently in execute against its fetch-time prediction
  always_comb begin
    correct_pc = ex_taken ? ex_target : ex_pc4;
    res_miss   = (ex_pred_dir != ex_taken) | (ex_pred_target != correct_pc);
    // BTB only needs rewriting when a taken branch's stored target was wrong or absent
    btb_wr     = ex_taken & (ex_pred_target != ex_target);
    res_be     = btb_wr ? 4'b1111 : 4'b0001;
  end

  // Queue handshakes: a full queue still accepts when the head leaves the same cycle
  always_comb begin
    not_empty = (count_q != '0);
    pop       = not_empty & ~soin_bpredictor_stall;
    push      = ex_valid & ((count_q < DEPTH_C) | pop);
    drop      = ex_valid & ~push;
  end

  // Next-state for pointers, occupancy and the redirect register
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    redir_valid_d = ex_valid & res_miss;
    redir_pc_d    = (ex_valid & res_miss) ? correct_pc : redir_pc_q;
  end

  // Pointer, count and redirect registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
    end
  end

  // Packet storage; cleared on reset so every head-driven output reads zero afterwards
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < QDEPTH; i++) begin
        pc4_q[i]   <= '0;
        tgt_q[i]   <= '0;
        dir_q[i]   <= 1'b0;
        miss_q[i]  <= 1'b0;
        bim_q[i]   <= '0;
        carry_q[i] <= '0;
        be_q[i]    <= '0;
      end
    end else if (push) begin
      pc4_q[wr_ptr_q]   <= ex_pc4;
      tgt_q[wr_ptr_q]   <= ex_target;
      dir_q[wr_ptr_q]   <= ex_taken;
      miss_q[wr_ptr_q]  <= res_miss;
      bim_q[wr_ptr_q]   <= ex_bimodal;
      carry_q[wr_ptr_q] <= ex_carry;
      be_q[wr_ptr_q]    <= res_be;
    end
  end

  // Head entry drives the predictor update ports directly
  always_comb begin
    execute_bpredictor_update  = not_empty;
    execute_bpredictor_PC4     = pc4_q[rd_ptr_q];
    execute_bpredictor_target  = tgt_q[rd_ptr_q];
    execute_bpredictor_dir     = dir_q[rd_ptr_q];
    execute_bpredictor_miss    = miss_q[rd_ptr_q];
    execute_bpredictor_bimodal = bim_q[rd_ptr_q];
    up_btb_data                = tgt_q[rd_ptr_q][31:2];
    up_carry_data              = carry_q[rd_ptr_q];
    byte_en                    = be_q[rd_ptr_q];
    redirect_valid             = redir_valid_q;
    redirect_pc                = redir_pc_q;
  end

`ifdef BPU_UPD_STATS_EN
  logic [31:0] st_push_q, st_drop_q, st_miss_q, st_redir_q;

  // Saturating event counters
  always_ff @(posedge clk) begin
    if (reset) begin
      st_push_q  <= '0;
      st_drop_q  <= '0;
      st_miss_q  <= '0;
      st_redir_q <= '0;
    end else begin
      if (push && st_push_q != 32'hFFFF_FFFF)
        st_push_q <= st_push_q + 32'd1;
      if (drop && st_drop_q != 32'hFFFF_FFFF)
        st_drop_q <= st_drop_q + 32'd1;
      if (ex_valid && res_miss && st_miss_q != 32'hFFFF_FFFF)
        st_miss_q <= st_miss_q + 32'd1;
      if (redir_valid_q && st_redir_q != 32'hFFFF_FFFF)
        st_redir_q <= st_redir_q + 32'd1;
    end
  end

  // Counter readback select
  always_comb begin
    case (stat_sel)
      2'b00:   stat_data = st_push_q;
      2'b01:   stat_data = st_drop_q;
      2'b10:   stat_data = st_miss_q;
      default: stat_data = st_redir_q;
    endcase
  end
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule
